// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the single-clock FIFO:
//   ptr_width() - pointer/count width for a given depth (clog2 + wrap bit)
//   depth_ok()  - depth must be a power of two and at least 2
//   af_ok()     - almost-full threshold legal range 1..DEPTH
//   ae_ok()     - almost-empty threshold legal range 0..DEPTH-1
// ---------------------------------------------------------------------------
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_ok(input int unsigned af, input int unsigned depth);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_ok(input int unsigned ae, input int unsigned depth);
        return ae < depth;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
// Bundles the FIFO's write, read, control and status signals.
//   master : producer/consumer side (drives winc/wdata/rinc/flush)
//   slave  : the FIFO itself (drives data, strobe and status outputs)
// ---------------------------------------------------------------------------
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
);
    localparam int unsigned CW = ptr_width(DEPTH);

    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             wfull;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             rempty;
    logic             flush;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;
    logic             ovf;
    logic             udf;

    modport master (
        output winc, wdata, rinc, flush,
        input  wfull, rdata, rvalid, rempty, count,
               almost_full, almost_empty, ovf, udf
    );

    modport slave (
        input  winc, wdata, rinc, flush,
        output wfull, rdata, rvalid, rempty, count,
               almost_full, almost_empty, ovf, udf
    );

endinterface

// File: rtl/fifo_ptr_ctr.sv
// ---------------------------------------------------------------------------
// fifo_ptr_ctr
// W-bit binary pointer with wrap bit. Wraps naturally from all-ones to zero.
//   clk - clock            rst - async active-high reset
//   clr - sync clear (priority over inc)
//   inc - advance by one   ptr - current pointer value
// ---------------------------------------------------------------------------
module fifo_ptr_ctr #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// registered read data with a one-cycle valid strobe, synchronous flush and
// sticky overflow/underflow flags.
//   clk - sole clock          rst - async active-high reset
//   bus - sync_fifo_param_if.slave: winc/wdata, rinc -> rdata/rvalid,
//         flush, wfull/rempty/count/almost_full/almost_empty, ovf/udf
// Status outputs depend only on registered pointers.
// ---------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AF_LVL = DEPTH - 4,
    parameter int unsigned AE_LVL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_fifo_param_if.slave     bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] AF_TH = PW'(AF_LVL);
    localparam logic [PW-1:0] AE_TH = PW'(AE_LVL);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be at least 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!af_ok(AF_LVL, DEPTH)) begin : g_bad_af
        $error("sync_fifo_param: AF_LVL must be in 1..DEPTH");
    end
    if (!ae_ok(AE_LVL, DEPTH)) begin : g_bad_ae
        $error("sync_fifo_param: AE_LVL must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    occ;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             ovf_q;
    logic             udf_q;

    // Full vs empty is resolved by the wrap bit: same slot, different lap.
    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign occ    = wptr - rptr;

    assign wr_acc = bus.winc && !full  && !bus.flush;
    assign rd_acc = bus.rinc && !empty && !bus.flush;

    fifo_ptr_ctr #(.W(PW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .inc (wr_acc),
        .ptr (wptr)
    );

    fifo_ptr_ctr #(.W(PW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .inc (rd_acc),
        .ptr (rptr)
    );

    // Array is never cleared; flush and reset only move the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wptr[AW-1:0]] <= bus.wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (bus.flush) begin
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc)
                rdata_q <= mem[rptr[AW-1:0]];
            if (bus.winc && full)
                ovf_q <= 1'b1;
            if (bus.rinc && empty)
                udf_q <= 1'b1;
        end
    end

    assign bus.wfull        = full;
    assign bus.rempty       = empty;
    assign bus.count        = occ;
    assign bus.almost_full  = (occ >= AF_TH);
    assign bus.almost_empty = (occ <= AE_TH);
    assign bus.rdata        = rdata_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param (WIDTH=16, DEPTH=8, AF_LVL=4, AE_LVL=2).
// Expected read data is queued when a read is issued; a monitor pops and
// compares whenever rvalid is seen. Status is checked against hand values.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AF_LVL = 4;
    localparam int unsigned AE_LVL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [WIDTH-1:0] mdl   [$];   // words currently held by the FIFO
    logic [WIDTH-1:0] exp_q [$];   // read responses still to be seen
    bit movf = 1'b0;
    bit mudf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, applied at a falling edge; returns at the next
    // falling edge with inputs idled.
    task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit f);
        bit full, empty;
        full  = (mdl.size() == DEPTH);
        empty = (mdl.size() == 0);
        bus.winc  = w;
        bus.wdata = d;
        bus.rinc  = r;
        bus.flush = f;
        if (f) begin
            mdl.delete();
            movf = 1'b0;
            mudf = 1'b0;
        end else begin
            if (r && !empty) exp_q.push_back(mdl.pop_front());
            else if (r)      mudf = 1'b1;
            if (w && !full)  mdl.push_back(d);
            else if (w)      movf = 1'b1;
        end
        @(negedge clk);
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.flush = 1'b0;
        chk("count_track", 32'(bus.count), 32'(mdl.size()));
        chk("ovf_track", 32'(bus.ovf), 32'(movf));
        chk("udf_track", 32'(bus.udf), 32'(mudf));
    endtask

    task automatic rd_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("rvalid_after_rinc", 32'(bus.rvalid), 32'd1);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation.
    initial begin
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (bus.rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rdata_unexpected: rvalid with 0x%0h, want no read", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", 32'(bus.rdata), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.winc  = 1'b0;
        bus.wdata = '0;
        bus.rinc  = 1'b0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset / idle state
        chk("rst_rempty", 32'(bus.rempty), 32'd1);
        chk("rst_wfull", 32'(bus.wfull), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        chk("rst_almost_full", 32'(bus.almost_full), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);

        // Fill 1..8, thresholds along the way
        for (int unsigned i = 1; i <= 8; i++) begin
            cyc(1'b1, WIDTH'(i), 1'b0, 1'b0);
            if (i == 2) chk("ae_at_2", 32'(bus.almost_empty), 32'd1);
            if (i == 3) begin
                chk("ae_at_3", 32'(bus.almost_empty), 32'd0);
                chk("af_at_3", 32'(bus.almost_full), 32'd0);
            end
            if (i == 4) chk("af_at_4", 32'(bus.almost_full), 32'd1);
        end
        chk("full_wfull", 32'(bus.wfull), 32'd1);
        chk("full_count", 32'(bus.count), 32'd8);
        chk("full_almost_full", 32'(bus.almost_full), 32'd1);
        cyc(1'b1, 16'h0009, 1'b0, 1'b0);
        chk("ovf_on_9th", 32'(bus.ovf), 32'd1);
        chk("count_after_9th", 32'(bus.count), 32'd8);
        rd_n(8);
        chk("drained_rempty", 32'(bus.rempty), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("idle_rvalid", 32'(bus.rvalid), 32'd0);
        chk("idle_rdata_hold", 32'(bus.rdata), 32'h8);

        // Streaming with one entry resident, across pointer wrap
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 16'h0100, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 20; i++) begin
            cyc(1'b1, WIDTH'(16'h0200 + i), 1'b1, 1'b0);
            chk("stream_count", 32'(bus.count), 32'd1);
        end
        rd_n(1);
        chk("stream_rempty", 32'(bus.rempty), 32'd1);

        // Full: simultaneous winc+rinc -> read wins
        for (int unsigned i = 0; i < 8; i++)
            cyc(1'b1, WIDTH'(16'h0030 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'h00AA, 1'b1, 1'b0);
        chk("full_rw_ovf", 32'(bus.ovf), 32'd1);
        chk("full_rw_count", 32'(bus.count), 32'd7);
        chk("full_rw_wfull", 32'(bus.wfull), 32'd0);
        rd_n(7);
        chk("pre_empty_udf", 32'(bus.udf), 32'd0);

        // Empty: simultaneous winc+rinc -> write wins
        cyc(1'b1, 16'h00BB, 1'b1, 1'b0);
        chk("empty_rw_udf", 32'(bus.udf), 32'd1);
        chk("empty_rw_count", 32'(bus.count), 32'd1);
        rd_n(1);

        // Flush with concurrent winc+rinc
        for (int unsigned i = 1; i <= 5; i++)
            cyc(1'b1, WIDTH'(16'h0060 + i), 1'b0, 1'b0);
        chk("load5_count", 32'(bus.count), 32'd5);
        chk("load5_ovf", 32'(bus.ovf), 32'd1);
        rd_n(1);
        cyc(1'b1, 16'h00CC, 1'b1, 1'b1);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_rempty", 32'(bus.rempty), 32'd1);
        chk("flush_ovf", 32'(bus.ovf), 32'd0);
        chk("flush_udf", 32'(bus.udf), 32'd0);
        chk("flush_rvalid", 32'(bus.rvalid), 32'd0);
        chk("flush_rdata_hold", 32'(bus.rdata), 32'h61);

        // Asynchronous reset between edges with three words held
        cyc(1'b0, '0, 1'b1, 1'b0);
        for (int unsigned i = 1; i <= 3; i++)
            cyc(1'b1, WIDTH'(16'h0040 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_rempty", 32'(bus.rempty), 32'd1);
        chk("arst_wfull", 32'(bus.wfull), 32'd0);
        chk("arst_rdata", 32'(bus.rdata), 32'd0);
        chk("arst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("arst_ovf", 32'(bus.ovf), 32'd0);
        chk("arst_udf", 32'(bus.udf), 32'd0);
        mdl.delete();
        exp_q.delete();
        movf = 1'b0;
        mudf = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        cyc(1'b1, 16'h0051, 1'b0, 1'b0);
        cyc(1'b1, 16'h0052, 1'b0, 1'b0);
        chk("post_rst_count", 32'(bus.count), 32'd2);
        rd_n(2);

        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
